// File: rtl/median_window_feeder.sv
// Raster-to-3x3 window feeder: buffers two lines, builds a sliding 3x3 window and
// streams its nine pixels to a median filter, then waits for the filter's result pulse.
module median_window_feeder #(
  parameter int W     = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] PI,
  input  logic         PVI,
  output logic         PRO,
  output logic [W-1:0] DO,
  output logic         DSO,
  input  logic         MDONE,
  output logic         FDONE,
  output logic [1:0]   state_dbg
);

  // Handshake: a pixel transfers on a rising edge where PVI and PRO are both 1;
  // PI must stay stable while PVI is held and PRO is 0. DSO marks each of the nine
  // window beats on DO; MDONE is a single-cycle pulse that only counts in WAIT.

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          fdone_q, fdone_d;

  logic [W-1:0]  lb0_q [IMG_W];
  logic [W-1:0]  lb0_d [IMG_W];
  logic [W-1:0]  lb1_q [IMG_W];
  logic [W-1:0]  lb1_d [IMG_W];
  logic [W-1:0]  win_q [9];
  logic [W-1:0]  win_d [9];

  logic          accept;

  assign accept    = (state_q == ACCEPT) && PVI;
  assign PRO       = (state_q == ACCEPT);
  assign DSO       = (state_q == SEND);
  assign DO        = DSO ? win_q[cnt_q] : '0;
  assign FDONE     = fdone_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    fdone_d = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (PVI) begin
          col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
          if (col_q == COL_LAST) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end
          // A full window exists once the incoming pixel is at least two rows and columns in.
          if ((row_q >= ROW_TWO) && (col_q >= COL_TWO)) begin
            state_d = SEND;
            cnt_d   = 4'd0;
            last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
          end
        end
      end
      SEND: begin
        if (cnt_q == 4'd8) begin
          state_d = WAIT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT: begin
        if (MDONE) begin
          state_d = ACCEPT;
          fdone_d = last_q;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // Window rows are stored row-major so DO can index beat k directly.
  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2]     = lb0_q[col_q];
      win_d[5]     = lb1_q[col_q];
      win_d[8]     = PI;
      lb0_d[col_q] = lb1_q[col_q];
      lb1_d[col_q] = PI;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ACCEPT;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      fdone_q <= fdone_d;
    end
  end

  // Pixel storage carries no reset; a fresh frame always refills two rows first.
  always_ff @(posedge CLK) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
    win_q <= win_d;
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder: a raster-image model predicts every window beat
// and the frame-done pulse; a negedge monitor compares what the DUT presents.
module tb_median_window_feeder;

  localparam int PW = 8;
  localparam int IW = 4;
  localparam int IH = 4;

  logic          CLK;
  logic          RST;
  logic [PW-1:0] PI;
  logic          PVI;
  logic          PRO;
  logic [PW-1:0] DO;
  logic          DSO;
  logic          MDONE;
  logic          FDONE;
  logic [1:0]    state_dbg;

  median_window_feeder #(.W(PW), .IMG_W(IW), .IMG_H(IH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PI        (PI),
    .PVI       (PVI),
    .PRO       (PRO),
    .DO        (DO),
    .DSO       (DSO),
    .MDONE     (MDONE),
    .FDONE     (FDONE),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard state (monitor-owned) ----------------
  logic [PW-1:0] exp_q[$];
  bit            lastw_q[$];
  logic [PW-1:0] img [IH][IW];
  int            mdl_n        = 0;
  int            n_checks     = 0;
  int            n_fail       = 0;
  int            acc_cnt      = 0;
  int            run          = 0;
  int            win_in_frame = 0;
  bit            in_wait      = 0;
  bit            send_due     = 0;
  bit            ret_due      = 0;
  bit            fdone_due    = 0;
  bit            win_last     = 0;
  bit            rst_prev     = 0;
  bit            tmo_done     = 0;

  // ---------------- driver state (driver-owned) ----------------
  int            acc_seen     = 0;
  int            pix_left     = 0;
  int            pvi_pct      = 100;
  int            ramp_val     = 0;
  int            mdone_delay  = 3;
  int            wait_cnt     = 0;
  int            dso_run      = 0;
  bit            ramp_mode    = 1;
  bit            rand_delay   = 0;
  bit            spurious_en  = 0;
  bit            tmo_flag     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      lastw_q.delete();
      mdl_n        = 0;
      run          = 0;
      win_in_frame = 0;
      in_wait      = 0;
      send_due     = 0;
      ret_due      = 0;
      fdone_due    = 0;
      rst_prev     = 1;
    end else begin
      if (rst_prev) begin
        chk("reset_pro", PRO, 1);
        chk("reset_dso", DSO, 0);
        chk("reset_do", DO, 0);
        chk("reset_fdone", FDONE, 0);
        rst_prev = 0;
      end
      chk("fdone", FDONE, fdone_due);
      if (fdone_due) begin
        chk("windows_per_frame", win_in_frame, (IW - 2) * (IH - 2));
        win_in_frame = 0;
      end
      fdone_due = 0;
      if (ret_due) begin
        chk("pro_after_mdone", PRO, 1);
        ret_due = 0;
      end
      if (send_due) begin
        chk("dso_start", DSO, 1);
        send_due = 0;
      end
      if (DSO) begin
        chk("pro_in_send", PRO, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dso got=DO %0d exp=no beat t=%0t", DO, $time);
        end else begin
          chk("window_beat", DO, exp_q.pop_front());
        end
        run++;
      end else begin
        chk("do_idle", DO, 0);
        if (run > 0) begin
          chk("beat_count", run, 9);
          run      = 0;
          win_last = (lastw_q.size() > 0) ? lastw_q.pop_front() : 1'b0;
          in_wait  = 1;
          win_in_frame++;
        end
      end
      if (in_wait) begin
        chk("pro_in_wait", PRO, 0);
        chk("dso_in_wait", DSO, 0);
        if (MDONE) begin
          in_wait   = 0;
          fdone_due = win_last;
          ret_due   = 1;
        end
      end
      if (PVI && PRO) begin
        int r;
        int c;
        acc_cnt++;
        r = mdl_n / IW;
        c = mdl_n % IW;
        img[r][c] = PI;
        // Interior centre: the window is the 3x3 block ending at the new pixel.
        if (r >= 2 && c >= 2) begin
          for (int dr = -2; dr <= 0; dr++)
            for (int dc = -2; dc <= 0; dc++)
              exp_q.push_back(img[r + dr][c + dc]);
          lastw_q.push_back(r == IH - 1 && c == IW - 1);
          send_due = 1;
        end
        mdl_n = (mdl_n + 1) % (IW * IH);
      end
      if (tmo_flag && !tmo_done) begin
        chk("drain_timeout", tmo_flag, 0);
        tmo_done = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
    if (DSO) dso_run++;
    else     dso_run = 0;
    MDONE = 1'b0;
    if (in_wait) begin
      if (wait_cnt == 0 && rand_delay) mdone_delay = $urandom_range(0, 6);
      if (wait_cnt == mdone_delay) MDONE = 1'b1;
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      // Stray pulses only while the DUT is in ACCEPT or mid-SEND, where they must be ignored.
      if (spurious_en && (PRO || (DSO && dso_run <= 8)) && $urandom_range(0, 2) == 0)
        MDONE = 1'b1;
    end
    if (acc_cnt != acc_seen) begin
      acc_seen = acc_cnt;
      PVI      = 1'b0;
      pix_left--;
    end
    if (!PVI && pix_left > 0 && $urandom_range(0, 99) < pvi_pct) begin
      PVI = 1'b1;
      PI  = ramp_mode ? ramp_val[PW-1:0] : PW'($urandom);
      ramp_val++;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((pix_left > 0 || PVI || exp_q.size() != 0 || in_wait || send_due || ret_due ||
            fdone_due) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      $display("note: drain stalled, dut state=%0d", state_dbg);
      tmo_flag = 1;
    end
    repeat (2) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    RST   = 1'b1;
    PVI   = 1'b0;
    PI    = '0;
    MDONE = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    repeat (2) step();

    // First frame: ramp 0..15, slow filter so pixel 11 is held through SEND/WAIT.
    ramp_mode   = 1;
    ramp_val    = 0;
    pvi_pct     = 100;
    mdone_delay = 20;
    pix_left    = IW * IH;
    drain(3000);

    // Second frame: ramp continues, quick filter, stray MDONE pulses.
    mdone_delay = 3;
    spurious_en = 1;
    pix_left    = IW * IH;
    drain(3000);

    // Random pixels, gappy valid, random filter latency.
    ramp_mode  = 0;
    pvi_pct    = 60;
    rand_delay = 1;
    pix_left   = 80;
    drain(6000);

    // Reset while beat k=4 of a window is on DO.
    pix_left = 40;
    k = 0;
    while (dso_run != 5 && k < 1000) begin
      step();
      k++;
    end
    if (k >= 1000) tmo_flag = 1;
    RST = 1'b1;
    step();
    RST = 1'b0;
    drain(6000);

    // Back-to-back random frames.
    pvi_pct  = 100;
    pix_left = 64;
    drain(6000);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/median_window_feeder.md
MEDIAN_WINDOW_FEEDER -- requirements
Module: median_window_feeder

Interface
REQ-001 SHALL have parameter W, default 8, meaning the pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 16, meaning the pixels per line; legal values are 3 or more.
REQ-003 SHALL have parameter IMG_H, default 16, meaning the lines per frame; legal values are 3 or more.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port PI, input, W bits: raster pixel in, row-major, top-left first.
REQ-007 SHALL have port PVI, input, 1 bit: PI valid.
REQ-008 SHALL have port PRO, output, 1 bit: ready; a pixel is accepted when PVI and PRO are both 1.
REQ-009 SHALL have port DO, output, W bits: serialized 3x3 window pixel to the median filter.
REQ-010 SHALL have port DSO, output, 1 bit: DO valid, driven to the median filter's data-strobe input.
REQ-011 SHALL have port MDONE, input, 1 bit: one-cycle median-result-ready pulse from the median filter.
REQ-012 SHALL have port FDONE, output, 1 bit: one-cycle pulse when the last window of a frame completes.

Function
REQ-013 SHALL hold two line buffers of IMG_W x W bits (L0 = row r-2, L1 = row r-1) and a 3x3 window register array.
REQ-014 SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) that advance on each accept, wrapping column to 0 with row+1 and row to 0 at frame end.
REQ-015 SHALL, on accepting pixel p at column c, shift the window left, load the new right column {top, mid, bot} = {L0[c], L1[c], p}, then write L0[c] <= L1[c] and L1[c] <= p.
REQ-016 SHALL use states ACCEPT, SEND and WAIT; PRO = 1 only in ACCEPT.
REQ-017 SHALL go from ACCEPT to SEND in the cycle after an accept with row >= 2 and col >= 2 (window centred on (row-1, col-1)); otherwise it SHALL stay in ACCEPT.
REQ-018 SHALL, in SEND, hold DSO = 1 for exactly 9 consecutive cycles, with DO in cycle k (k = 0..8) = window element k in row-major order (top-left, top-mid, top-right, mid-left, ..., bottom-right), then go to WAIT.
REQ-019 SHALL, in WAIT, hold DSO = 0 and PRO = 0 until MDONE = 1, then go to ACCEPT in the next cycle.
REQ-020 SHALL ignore MDONE in ACCEPT and SEND.
REQ-021 SHALL drive DO = 0 whenever DSO = 0.
REQ-022 SHALL emit windows for interior centres only: (IMG_W-2) x (IMG_H-2) windows per frame, with no border outputs.
REQ-023 SHALL pulse FDONE for one cycle, coincident with the WAIT to ACCEPT transition, when the window just completed was triggered by the pixel at (IMG_H-1, IMG_W-1).
REQ-024 SHALL freeze the window, line buffers and counters while in SEND and WAIT, which is guaranteed because PRO = 0.
REQ-025 SHALL make a new frame refill two rows before emitting any window, because the row counter is back at 0; stale line-buffer data is never emitted.
REQ-026 SHALL tolerate an unbounded MDONE delay, staying in WAIT with no timeout.

Reset
REQ-027 SHALL, while RST = 1 at a clock edge, set state to ACCEPT and row, column and send counters to 0; PRO = 1, DSO = 0, DO = 0, FDONE = 0 in the following cycle.
REQ-028 SHALL allow reset at any state, including mid-SEND; DSO SHALL drop in the next cycle and no partial window is resumed.
REQ-029 SHALL leave line-buffer and window contents unreset, because they are don't-care per REQ-025.

Verification
REQ-030 SHALL verify reset: RST = 1 for 2 cycles -> PRO = 1, DSO = 0, DO = 0, FDONE = 0.
REQ-031 SHALL verify first window: IMG_W = IMG_H = 4, ramp PI = 0..10 with PVI = 1 -> after pixel 10 is accepted, DSO = 1 for 9 cycles with DO = 0,1,2,4,5,6,8,9,10; PRO = 0 from the cycle after the accept.
REQ-032 SHALL verify backpressure: PVI held with PI = 11 during SEND/WAIT -> not accepted; MDONE 20 cycles late -> DSO = 0 and PRO = 0 throughout, then 11 is accepted in the cycle after MDONE and the next window is 1,2,3,5,6,7,9,10,11.
REQ-033 SHALL verify frame end: full 4x4 ramp with MDONE 3 cycles after each DSO fall -> exactly 4 windows; FDONE pulses once after the 4th MDONE; the next frame's first window appears only after its pixel (2,2).
REQ-034 SHALL verify reset mid-operation: RST asserted at SEND k = 4 -> DSO = 0 next cycle; the next window appears only after two fresh rows are accepted.
REQ-035 SHALL verify spurious MDONE: MDONE pulsed in ACCEPT and in SEND -> no state change, DSO sequence unchanged.
